// File: rtl/alu_serial_pkg.sv
// Shared types for the bit-serial ALU engine: operation codes, FSM states and
// a helper that tells carry-chain operations apart from bitwise ones.
package alu_serial_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // ADD and SUB use the carry chain; NOR and XOR never produce carry or overflow.
  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: bitwise NOR/XOR or a full adder for ADD/SUB.
// Subtraction is handled by the caller (inverted b, carry-in seeded to 1).
module alu_bit_slice
  import alu_serial_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e op,
  output logic    s,
  output logic    cout
);

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      default: begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU engine: operands are accepted over valid/ready, evaluated LSB-first
// through one alu_bit_slice per clock, and returned over valid/ready. Define
// ALU_OVF_FLAG_EN to build the signed-overflow flag and its ovf port.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
`ifdef ALU_OVF_FLAG_EN
  output logic         zero,
  output logic         ovf
`else
  output logic         zero
`endif
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_e         state, state_nxt;
  logic [W-1:0]   a_sh, b_sh, res_sh;
  alu_op_e        op_q;
  alu_op_e        op_in;
  logic [CNT_W-1:0] count;
  logic           carry;

  logic           accept, shift_en, last_bit;
  logic           slice_b, slice_s, slice_cout;
  logic [W-1:0]   res_next;

  logic [W-1:0]   result_q;
  logic           cout_q, zero_q;

  assign op_in = alu_op_e'(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (count == CNT_LAST) begin
          last_bit  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE first keeps a new request from landing in the handoff cycle.
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Subtraction as a + ~b + 1: invert b per bit, carry seeded to 1 at acceptance.
  assign slice_b  = b_sh[0] ^ (op_q == OP_SUB);
  assign res_next = {slice_s, res_sh[W-1:1]};

  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (slice_b),
    .cin  (carry),
    .op   (op_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Shift stage: operand/result shift registers, bit counter and carry flip-flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= OP_NOR;
      count  <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      op_q   <= op_in;
      count  <= '0;
      carry  <= (op_in == OP_SUB);
    end else if (shift_en) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      carry  <= slice_cout;
      count  <= count + CNT_W'(1);
    end
  end

  // Output stage: flags and result captured on the final bit, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (last_bit) begin
      result_q <= res_next;
      cout_q   <= is_arith(op_q) ? slice_cout : 1'b0;
      zero_q   <= (res_next == '0);
    end
  end

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= is_arith(op_q) & (carry ^ slice_cout);
  end

  assign ovf = ovf_q;
`endif

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (W=8): directed spec cases, randomized
// operations against an arithmetic reference model, backpressure and mid-op reset.
module tb_alu_serial_ctrl;

  localparam int W    = 8;
  localparam int SMAX = 2**(W-1) - 1;
  localparam int SMIN = -(2**(W-1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
`ifdef ALU_OVF_FLAG_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
`ifdef ALU_OVF_FLAG_EN
    .zero      (zero),
    .ovf       (ovf)
`else
    .zero      (zero)
`endif
  );

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [1:0] o, output logic [W-1:0] r,
                                output logic c, output logic z, output logic v);
    int unsigned ux, uy, us;
    int sx, sy, ss;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    c = 1'b0; v = 1'b0; r = '0;
    case (o)
      2'd0: r = ~(x | y);
      2'd1: r = x ^ y;
      2'd2: begin
        us = ux + uy; r = us[W-1:0]; c = (us >= (1 << W));
        ss = sx + sy; v = (ss > SMAX) || (ss < SMIN);
      end
      default: begin
        us = ux - uy; r = us[W-1:0]; c = (ux >= uy);
        ss = sx - sy; v = (ss > SMAX) || (ss < SMIN);
      end
    endcase
    z = (r == '0);
  endfunction

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
  endtask

  // Issue one request from IDLE and stop once out_valid is seen (DUT left in DONE).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                        input bit scramble, output int edges);
    @(negedge clk);
    a = x; b = y; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 4*W) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if (cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL reset_flags got cout=%b zero=%b exp=0,0", cout, zero); end
`ifdef ALU_OVF_FLAG_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{8'hFF, 8'h05, 8'h07, 8'hF0, 8'hAA};
    logic [W-1:0] tb[5] = '{8'h01, 8'h07, 8'h05, 8'h0C, 8'hAA};
    logic [1:0]   to[5] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
    logic [W-1:0] er[5] = '{8'h00, 8'hFE, 8'h02, 8'h03, 8'h00};
    logic         ec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         ez[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit ok;
    int edges;
    for (int i = 0; i < 5; i++) begin
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL dir_idle_timeout case=%0d", i); end
      run_op(ta[i], tb[i], to[i], 1'b0, edges);
      total++; if (edges !== W + 1) begin bad++; $display("FAIL dir_latency case=%0d got=%0d exp=%0d", i, edges, W + 1); end
      total++;
      if (result !== er[i] || cout !== ec[i] || zero !== ez[i]) begin
        bad++;
        $display("FAIL dir_result case=%0d got r=%h c=%b z=%b exp r=%h c=%b z=%b",
                 i, result, cout, zero, er[i], ec[i], ez[i]);
      end
      consume();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL dir_release case=%0d got in_ready=%b out_valid=%b exp=1,0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, r;
    logic [1:0]   o;
    logic         c, z, v;
    bit ok;
    int edges;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); o = 2'($urandom);
      if (i < 4) o = 2'(i);
      model(x, y, o, r, c, z, v);
      wait_idle(ok);
      run_op(x, y, o, 1'b1, edges);
      total++;
      if (!ok || edges !== W + 1 || result !== r || cout !== c || zero !== z) begin
        bad++;
        $display("FAIL rand op=%0d a=%h b=%h got r=%h c=%b z=%b edges=%0d exp r=%h c=%b z=%b edges=%0d",
                 o, x, y, result, cout, zero, edges, r, c, z, W + 1);
      end
`ifdef ALU_OVF_FLAG_EN
      total++; if (ovf !== v) begin bad++; $display("FAIL rand_ovf op=%0d a=%h b=%h got=%b exp=%b", o, x, y, ovf, v); end
`endif
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r;
    logic         c, z, v;
    bit ok;
    int edges;
    model(8'h3C, 8'h55, 2'd2, r, c, z, v);
    wait_idle(ok);
    run_op(8'h3C, 8'h55, 2'd2, 1'b0, edges);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2); a = 8'h11; b = 8'h22; op = 2'd3;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r || cout !== c || zero !== z) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b r=%h c=%b z=%b exp v=1 rdy=0 r=%h c=%b z=%b",
                 i, out_valid, in_ready, result, cout, zero, r, c, z);
      end
    end
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_handoff got in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid); end
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_accept got in_ready=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int edges;
    wait_idle(ok);
    @(negedge clk);
    a = 8'h9A; b = 8'h13; op = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || result !== '0) begin bad++; $display("FAIL midrst_clear got out_valid=%b result=%h exp=0,00", out_valid, result); end
    total++; if (cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL midrst_flags got cout=%b zero=%b exp=0,0", cout, zero); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle got in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid); end
    run_op(8'h01, 8'h01, 2'd2, 1'b0, edges);
    total++; if (edges !== W + 1 || result !== 8'h02 || cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL midrst_next got r=%h c=%b z=%b edges=%0d exp r=02 c=0 z=0 edges=%0d", result, cout, zero, edges, W + 1); end
    consume();
  endtask

`ifdef ALU_OVF_FLAG_EN
  task automatic test_ovf();
    logic [W-1:0] ta[3] = '{8'h7F, 8'h80, 8'h5A};
    logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'hC3};
    logic [1:0]   to[3] = '{2'd2, 2'd3, 2'd1};
    logic [W-1:0] er[3] = '{8'h80, 8'h7F, 8'h99};
    logic         ev[3] = '{1'b1, 1'b1, 1'b0};
    bit ok;
    int edges;
    for (int i = 0; i < 3; i++) begin
      wait_idle(ok);
      run_op(ta[i], tb[i], to[i], 1'b0, edges);
      total++; if (result !== er[i] || ovf !== ev[i]) begin bad++; $display("FAIL ovf case=%0d got r=%h ovf=%b exp r=%h ovf=%b", i, result, ovf, er[i], ev[i]); end
      consume();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
`ifdef ALU_OVF_FLAG_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
